// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad responder: FSM states, key width and
// helpers that split a linear key index into its row and column.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic int key_row(input logic [KEY_W-1:0] key, input int cols);
    return int'(key) / cols;
  endfunction

  function automatic int key_col(input logic [KEY_W-1:0] key, input int cols);
    return int'(key) % cols;
  endfunction

endpackage

// File: rtl/keypad_cmd_fifo.sv
// Small command FIFO with show-ahead read data and full/empty flags.
// Storage is an array written on push; the head entry is always visible.
module keypad_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/keypad_responder.sv
// Emulates a matrix keypad: queued press commands are replayed as a bounce,
// a stable hold and a release gap, answering the scanner's column drive on rows.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int Rows       = 4,
  parameter int Columns    = 4,
  parameter int HOLD_W     = 8,
  parameter int BOUNCE_CYC = 3,
  parameter int GAP_CYC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KEY_W-1:0]   cmd_key,
  input  logic [HOLD_W-1:0]  cmd_hold,
  input  logic [Columns-1:0] columns,
  output logic [Rows-1:0]    rows,
  output logic               busy,
  output logic               done
);

  localparam int CMD_W   = KEY_W + HOLD_W;
  localparam int CNT_MAX = (2**HOLD_W > BOUNCE_CYC) ?
                           ((2**HOLD_W > GAP_CYC) ? 2**HOLD_W : GAP_CYC) :
                           ((BOUNCE_CYC > GAP_CYC) ? BOUNCE_CYC : GAP_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pressed_q, pressed_d;
  logic                done_q, done_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    hold_last;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CMD_W-1:0]    fifo_head;
  logic [Columns-1:0]  col_hit;
  logic                col_low;
  int                  row_idx;
  int                  col_idx;

  keypad_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_key, cmd_hold}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A zero hold length still produces one stable cycle.
  assign hold_last = (hold_q == '0) ? '0 : CNT_W'(hold_q) - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    done_d    = 1'b0;
    key_d     = key_q;
    hold_d    = hold_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          key_d     = fifo_head[CMD_W-1 -: KEY_W];
          hold_d    = fifo_head[HOLD_W-1:0];
          cnt_d     = '0;
          pressed_d = 1'b1;
          state_d   = ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (cnt_q == CNT_W'(BOUNCE_CYC - 1)) begin
          cnt_d     = '0;
          pressed_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          pressed_d = ~pressed_q;
        end
      end
      ST_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d     = '0;
          pressed_d = 1'b0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      key_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      done_q    <= done_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    row_idx = key_row(key_q, Columns);
    col_idx = key_col(key_q, Columns);
  end

  // Only the latched key's own column matters; other low columns are ignored.
  for (genvar gi = 0; gi < Columns; gi++) begin : g_col
    assign col_hit[gi] = (col_idx == gi) && !columns[gi];
  end
  assign col_low = |col_hit;

  for (genvar gi = 0; gi < Rows; gi++) begin : g_row
    assign rows[gi] = ~(pressed_q && col_low && (row_idx == gi));
  end

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_responder.sv
// Self-checking bench for keypad_responder: fixed vector table, directed
// corner sequences and a random run against a press-timeline reference model.
module tb_keypad_responder;

  localparam int COLS   = 4;
  localparam int BOUNCE = 3;
  localparam int GAP    = 4;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold;
  logic [3:0] columns;
  logic       cmd_ready;
  logic [3:0] rows;
  logic       busy;
  logic       done;

  keypad_responder #(
    .Rows       (4),
    .Columns    (COLS),
    .HOLD_W     (8),
    .BOUNCE_CYC (BOUNCE),
    .GAP_CYC    (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .columns   (columns),
    .rows      (rows),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued commands plus a per-cycle timeline of the
  // pressed level for the command currently being replayed.
  logic [3:0] mq_key[$];
  logic [7:0] mq_hold[$];
  bit         tl[$];
  logic [3:0] m_key;
  bit         m_done;

  function automatic logic [3:0] m_rows(input bit p, input logic [3:0] key, input logic [3:0] cols);
    logic [3:0] r;
    logic [1:0] rr;
    logic [1:0] cc;
    r  = 4'hF;
    rr = 2'(key / COLS);
    cc = 2'(key % COLS);
    if (p && cols[cc] == 1'b0) r[rr] = 1'b0;
    return r;
  endfunction

  task automatic m_reset();
    mq_key.delete();
    mq_hold.delete();
    tl.delete();
    m_done = 0;
    m_key  = '0;
  endtask

  task automatic m_edge();
    bit acc;
    bit nd;
    int h;
    if (reset) begin
      m_reset();
    end else begin
      acc = cmd_valid && (mq_key.size() < DEPTH);
      nd  = 0;
      if (tl.size() == 0) begin
        if (mq_key.size() > 0) begin
          m_key = mq_key.pop_front();
          h     = int'(mq_hold.pop_front());
          if (h == 0) h = 1;
          for (int i = 0; i < BOUNCE; i++) tl.push_back(i % 2 == 0);
          for (int i = 0; i < h; i++) tl.push_back(1'b1);
          for (int i = 0; i < GAP; i++) tl.push_back(1'b0);
        end
      end else begin
        void'(tl.pop_front());
        if (tl.size() == 0) nd = 1;
      end
      if (acc) begin
        mq_key.push_back(cmd_key);
        mq_hold.push_back(cmd_hold);
      end
      m_done = nd;
    end
  endtask

  logic [3:0] obs_rows;
  logic       obs_done;
  logic [3:0] rec[$];
  bit         armed;
  int         done_cnt;
  int         low_cnt;

  // One cycle: compare against the model, take the edge, advance the model.
  task automatic tick();
    bit p;
    #1;
    p = (tl.size() > 0) ? tl[0] : 1'b0;
    obs_rows = rows;
    obs_done = done;
    check("rows",  rows,      m_rows(p, m_key, columns));
    check("ready", cmd_ready, (mq_key.size() < DEPTH));
    check("busy",  busy,      (tl.size() > 0) || (mq_key.size() > 0));
    check("done",  done,      m_done);
    if (armed && obs_rows != 4'hF) begin
      rec.push_back(obs_rows);
      armed = 0;
    end
    if (obs_done) begin
      armed = 1;
      done_cnt++;
    end
    if (obs_rows != 4'hF) low_cnt++;
    $display("cyc t=%0t rst=%0b vld=%0b key=%0d hold=%0d cols=%b rows=%b rdy=%0b busy=%0b done=%0b",
             $time, reset, cmd_valid, cmd_key, cmd_hold, columns, rows, cmd_ready, busy, done);
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] cols);
    cmd_valid = 0;
    reset     = 0;
    columns   = cols;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic       vld;
    logic [3:0] key;
    logic [7:0] hold;
    logic [3:0] cols;
    logic [3:0] e_rows;
    logic       e_ready;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] r, input logic rd, input logic b, input logic d);
    vec_t e;
    e.vld = v; e.key = 4'd6; e.hold = 8'd5; e.cols = 4'b1011;
    e.e_rows = r; e.e_ready = rd; e.e_busy = b; e.e_done = d;
    tbl.push_back(e);
  endtask

  logic [3:0] rot [4];
  logic [3:0] exp_rec [5];
  logic [3:0] keys5 [5];
  int bad;
  int hits;

  initial begin
    rot     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    keys5   = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1};
    exp_rec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    armed = 0; done_cnt = 0; low_cnt = 0;
    reset = 1; cmd_valid = 0; cmd_key = 0; cmd_hold = 0; columns = 4'hF;
    m_reset();

    // Single-cycle reset
    @(posedge clk);
    m_reset();
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_rows",  rows,      4'hF);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy",  busy,      1'b0);
    check("rst_done",  done,      1'b0);

    // Key 6, hold 5, columns 1011: fixed expected sequence
    add(1, 4'hF, 1, 0, 0);
    add(0, 4'hF, 1, 1, 0);
    add(0, 4'b1101, 1, 1, 0);
    add(0, 4'b1111, 1, 1, 0);
    add(0, 4'b1101, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b1101, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 1, 0);
    add(0, 4'hF, 1, 0, 1);
    add(0, 4'hF, 1, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].vld; cmd_key = tbl[i].key;
      cmd_hold = tbl[i].hold; columns = tbl[i].cols;
      #1;
      check($sformatf("tbl%0d_rows", i),  rows,      tbl[i].e_rows);
      check($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_busy", i),  busy,      tbl[i].e_busy);
      check($sformatf("tbl%0d_done", i),  done,      tbl[i].e_done);
      tick();
    end

    // Rotating column drive
    bad = 0; hits = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_valid = (i == 0); cmd_key = 4'd6; cmd_hold = 8'd5;
      columns = rot[i % 4];
      tick();
      if (obs_rows != 4'hF && columns != 4'b1011) bad++;
      if (obs_rows == 4'b1101) hits++;
    end
    check("rot_bad", bad, 0);
    check("rot_hits", hits, 2);
    idle(4, 4'hF);

    // Five back-to-back commands, FIFO fills with one in flight
    rec.delete(); armed = 1; done_cnt = 0;
    columns = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1; cmd_key = keys5[i]; cmd_hold = 8'd2;
      #1;
      check($sformatf("b2b_ready%0d", i), cmd_ready, 1'b1);
      tick();
    end
    cmd_valid = 0;
    #1;
    check("b2b_full", cmd_ready, 1'b0);
    idle(70, 4'b0000);
    check("b2b_dones", done_cnt, 5);
    check("b2b_nrec", rec.size(), 5);
    for (int i = 0; i < 5 && i < rec.size(); i++)
      check($sformatf("b2b_order%0d", i), rec[i], exp_rec[i]);

    // Zero hold gives exactly one stable cycle
    low_cnt = 0;
    cmd_valid = 1; cmd_key = 4'd5; cmd_hold = 8'd0; columns = 4'b0000;
    tick();
    idle(20, 4'b0000);
    check("hold0_low", low_cnt, 3);

    // Reset in HOLD with two commands still queued
    columns = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_key = 4'd9; cmd_hold = 8'd10;
      tick();
    end
    idle(2, 4'b0000);
    reset = 1;
    tick();
    check("mid_hold_rows", obs_rows, 4'b1011);
    reset = 0;
    #1;
    check("abort_rows",  rows,      4'hF);
    check("abort_busy",  busy,      1'b0);
    check("abort_done",  done,      1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    low_cnt = 0; done_cnt = 0;
    idle(60, 4'b0000);
    check("abort_presses", low_cnt, 0);
    check("abort_dones", done_cnt, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_key   = 4'($urandom_range(0, 15));
      cmd_hold  = 8'($urandom_range(0, 6));
      columns   = 4'($urandom_range(0, 15));
      tick();
    end
    idle(4, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
